// File: rtl/eth_filter_pkg.sv
// Shared definitions for the Ethernet RX destination-address filter.
//   state_t    : filter FSM states
//   HDR_BYTES  : destination-address length in bytes
//   BCAST_ADDR : all-ones broadcast destination
package eth_filter_pkg;

  typedef enum logic [2:0] {
    HDR    = 3'd0,
    DECIDE = 3'd1,
    REPLAY = 3'd2,
    PASS   = 3'd3,
    DROP   = 3'd4
  } state_t;

  localparam int unsigned HDR_BYTES  = 6;
  localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_rx_addr_filter.sv
// Ethernet RX destination-address filter.
// Buffers the 6-byte destination address of each frame, decides for one cycle
// whether the frame is for this station, then either replays the buffered
// header followed by a zero-latency pass-through of the rest of the frame, or
// swallows the frame.
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   mac_addr[47:0]     : station address, first wire byte in [47:40]
//   promisc            : accept any frame of 7 or more bytes
//   s_axis_*           : 8-bit AXI-stream input from the MAC RX FIFO
//   m_axis_*           : 8-bit AXI-stream filtered output
//   frames_passed      : wrapping count of forwarded frames
//   frames_dropped     : wrapping count of discarded frames
//
// Build option: define ETH_RX_FILTER_BCAST_EN to accept ff:ff:ff:ff:ff:ff
// regardless of mac_addr.
module eth_rx_addr_filter
  import eth_filter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [47:0]          mac_addr,
  input  logic                 promisc,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [CNT_WIDTH-1:0] frames_passed,
  output logic [CNT_WIDTH-1:0] frames_dropped
);

  localparam logic [2:0] LAST_IDX = 3'(HDR_BYTES - 1);

  state_t      state;
  logic [2:0]  idx;
  logic [7:0]  hdr_buf [HDR_BYTES];
  logic [47:0] hdr_addr;
  logic        bcast_hit;
  logic        match;

  always_comb begin
    hdr_addr = '0;
    for (int unsigned i = 0; i < HDR_BYTES; i++) begin
      hdr_addr[47 - 8*i -: 8] = hdr_buf[i];
    end
  end

`ifdef ETH_RX_FILTER_BCAST_EN
  assign bcast_hit = (hdr_addr == BCAST_ADDR);
`else
  assign bcast_hit = 1'b0;
`endif

  // Only consulted in DECIDE, so mac_addr/promisc are effectively sampled there.
  assign match = promisc | (hdr_addr == mac_addr) | bcast_hit;

  // Outputs are decoded from state; PASS is a pure combinational wire-through.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    unique case (state)
      HDR:    s_axis_tready = 1'b1;
      DECIDE: s_axis_tready = 1'b0;
      REPLAY: begin
        m_axis_tdata  = hdr_buf[idx];
        m_axis_tvalid = 1'b1;
      end
      PASS: begin
        s_axis_tready = m_axis_tready;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
      end
      DROP:   s_axis_tready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= HDR;
      idx            <= '0;
      frames_passed  <= '0;
      frames_dropped <= '0;
      for (int unsigned i = 0; i < HDR_BYTES; i++) begin
        hdr_buf[i] <= '0;
      end
    end else begin
      unique case (state)
        HDR: begin
          if (s_axis_tvalid) begin
            hdr_buf[idx] <= s_axis_tdata;
            if (s_axis_tlast) begin
              // Runt frame: ended inside the address field.
              frames_dropped <= frames_dropped + CNT_WIDTH'(1);
              idx            <= '0;
            end else if (idx == LAST_IDX) begin
              state <= DECIDE;
              idx   <= '0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        DECIDE: begin
          if (match) begin
            state <= REPLAY;
          end else begin
            state          <= DROP;
            frames_dropped <= frames_dropped + CNT_WIDTH'(1);
          end
        end
        REPLAY: begin
          if (m_axis_tready) begin
            if (idx == LAST_IDX) begin
              state <= PASS;
              idx   <= '0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        PASS: begin
          if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
            state         <= HDR;
            frames_passed <= frames_passed + CNT_WIDTH'(1);
          end
        end
        DROP: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            state <= HDR;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_addr_filter.sv
module tb_eth_rx_addr_filter;

  localparam int CW = 4;
  localparam logic [47:0] MY_ADDR    = 48'h0200_0000_0001;
  localparam logic [47:0] OTHER_ADDR = 48'h0200_0000_0002;
  localparam logic [47:0] BC_ADDR    = 48'hFFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [47:0]   mac_addr = MY_ADDR;
  logic          promisc = 1'b0;
  logic [7:0]    s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic [CW-1:0] frames_passed;
  logic [CW-1:0] frames_dropped;

  eth_rx_addr_filter #(.CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .mac_addr       (mac_addr),
    .promisc        (promisc),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .frames_passed  (frames_passed),
    .frames_dropped (frames_dropped)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  beat_t      exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         exp_pass = 0;
  int         exp_drop = 0;
  logic [7:0] frame [0:127];
  bit         toggle_ready = 1'b0;
  bit         bcast_en;

`ifdef ETH_RX_FILTER_BCAST_EN
  initial bcast_en = 1'b1;
`else
  initial bcast_en = 1'b0;
`endif

  // Sink backpressure: toggles every cycle when enabled, otherwise always ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_ready) m_axis_tready = ~m_axis_tready;
      else              m_axis_tready = 1'b1;
    end
  end

  // Monitor: every output handshake is popped against the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    beat_t g;
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      n_vec++;
      g = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL out_beat: got data=%h last=%b user=%b, required no beat",
                 m_axis_tdata, m_axis_tlast, m_axis_tuser);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          n_bad++;
          $display("FAIL out_beat: got data=%h last=%b user=%b, required data=%h last=%b user=%b",
                   g.data, g.last, g.user, e.data, e.last, e.user);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] req);
    n_vec++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic check_counters(input string tag);
    @(negedge clk);
    check({tag, "_passed"},  48'(frames_passed),  48'(exp_pass % (1 << CW)));
    check({tag, "_dropped"}, 48'(frames_dropped), 48'(exp_drop % (1 << CW)));
    @(posedge clk);
    #1;
  endtask

  task automatic build_frame(input logic [47:0] dst, input int len, input int seed);
    for (int i = 0; i < 6; i++) frame[i] = dst[47 - 8*i -: 8];
    for (int i = 6; i < len; i++) frame[i] = 8'(i * 13 + seed);
  endtask

  // Drives beats 0..stop-1 of a len-byte frame; header beats carry tuser=1,
  // which must not reach the output.
  task automatic send_frame(input int len, input bit tuser_last, input bit pass, input int stop);
    int cyc;
    if (pass) begin
      for (int i = 0; i < stop; i++) begin
        exp_q.push_back({frame[i], (i == len - 1), ((i == len - 1) ? tuser_last : 1'b0)});
      end
    end
    for (int i = 0; i < stop; i++) begin
      s_axis_tdata  = frame[i];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == len - 1);
      s_axis_tuser  = (i < 6) ? 1'b1 : ((i == len - 1) ? tuser_last : 1'b0);
      cyc = 0;
      @(negedge clk);
      while (!s_axis_tready && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      if (!s_axis_tready) begin
        n_vec++;
        n_bad++;
        $display("FAIL in_accept: got no tready for beat %0d, required acceptance within 200 cycles", i);
        s_axis_tvalid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    if (stop == len) begin
      if (pass) exp_pass++;
      else      exp_drop++;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_tready", 48'(s_axis_tready), 48'd1);
    check("rst_m_tvalid", 48'(m_axis_tvalid), 48'd0);
    check("rst_m_tdata",  48'(m_axis_tdata),  48'd0);
    check("rst_m_tlast_tuser", 48'({m_axis_tlast, m_axis_tuser}), 48'd0);
    check("rst_counters", 48'({frames_passed, frames_dropped}), 48'd0);
    @(posedge clk);
    #1;

    // Matching 64-byte frame.
    build_frame(MY_ADDR, 64, 1);
    send_frame(64, 1'b0, 1'b1, 64);
    check_counters("match64");

    // Foreign address dropped, then a matching frame passes.
    build_frame(OTHER_ADDR, 64, 2);
    send_frame(64, 1'b0, 1'b0, 64);
    check_counters("other64");
    build_frame(MY_ADDR, 64, 3);
    send_frame(64, 1'b0, 1'b1, 64);
    check_counters("after_drop");

    // Broadcast: outcome depends on build option.
    build_frame(BC_ADDR, 60, 4);
    send_frame(60, 1'b0, bcast_en, 60);
    check_counters("bcast60");

    // Promiscuous: 7 bytes is the shortest accepted, 6 bytes is a runt.
    promisc = 1'b1;
    build_frame(OTHER_ADDR, 7, 5);
    send_frame(7, 1'b1, 1'b1, 7);
    check_counters("promisc7");
    build_frame(OTHER_ADDR, 6, 6);
    send_frame(6, 1'b0, 1'b0, 6);
    check_counters("promisc6");
    promisc = 1'b0;

    // 4-byte runt, then a matching frame.
    build_frame(MY_ADDR, 4, 7);
    send_frame(4, 1'b0, 1'b0, 4);
    @(negedge clk);
    check("runt_hdr_state", 48'({s_axis_tready, m_axis_tvalid}), 48'b10);
    @(posedge clk);
    #1;
    check_counters("runt4");
    build_frame(MY_ADDR, 64, 8);
    send_frame(64, 1'b0, 1'b1, 64);
    check_counters("after_runt");

    // Output backpressure every other cycle, error flag on the last beat.
    toggle_ready = 1'b1;
    build_frame(MY_ADDR, 40, 9);
    send_frame(40, 1'b1, 1'b1, 40);
    toggle_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_counters("toggle40");

    // Drive the drop counter through its wrap point.
    build_frame(MY_ADDR, 2, 10);
    while (exp_drop < 18) send_frame(2, 1'b0, 1'b0, 2);
    check_counters("drop_wrap");

    // Reset while byte 20 of a passing frame is on the bus.
    build_frame(MY_ADDR, 64, 11);
    send_frame(64, 1'b0, 1'b1, 20);
    s_axis_tdata  = frame[20];
    s_axis_tvalid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_m_tvalid", 48'(m_axis_tvalid), 48'd0);
    check("midrst_m_tdata",  48'(m_axis_tdata),  48'd0);
    check("midrst_counters", 48'({frames_passed, frames_dropped}), 48'd0);
    check("midrst_queue", 48'(exp_q.size()), 48'd0);
    s_axis_tvalid = 1'b0;
    exp_pass = 0;
    exp_drop = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    build_frame(MY_ADDR, 64, 12);
    send_frame(64, 1'b0, 1'b1, 64);
    check_counters("after_rst");

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("final_queue_empty", 48'(exp_q.size()), 48'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_rx_addr_filter.md
ETH_RX_ADDR_FILTER -- requirements
Module: eth_rx_addr_filter

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the frame counters.
REQ-002 SHALL have port clk  input  1  sole clock, 125 MHz MAC logic clock.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port mac_addr  input  48  station address; first wire byte = mac_addr[47:40].
REQ-005 SHALL have port promisc  input  1  when 1, accept every frame of 7 or more bytes.
REQ-006 SHALL have ports s_axis_tdata/tvalid/tready/tlast/tuser  input/input/output/input/input  8/1/1/1/1  frame stream from the MAC RX FIFO.
REQ-007 SHALL have ports m_axis_tdata/tvalid/tready/tlast/tuser  output/output/input/output/output  8/1/1/1/1  filtered frame stream.
REQ-008 SHALL have ports frames_passed, frames_dropped  output  CNT_WIDTH  wrapping event counters.

Function
REQ-009 SHALL implement states HDR, DECIDE, REPLAY, PASS, DROP.
REQ-010 HDR: s_axis_tready=1, m_axis_tvalid=0; each accepted beat stored into 6-byte header buffer at index 0..5.
REQ-011 HDR: on 6th accepted beat with tlast=0 -> DECIDE; a beat with tlast=1 at any index 0..5 discards the frame, increments frames_dropped, stays HDR with index 0.
REQ-012 DECIDE (exactly one cycle, s_axis_tready=0): match = promisc | (buffer==mac_addr) | broadcast (REQ-024); match -> REPLAY, else frames_dropped+1 and -> DROP.
REQ-013 mac_addr and promisc SHALL be sampled only in the DECIDE cycle.
REQ-014 REPLAY: s_axis_tready=0; drive buffer bytes 0..5 in order with m_axis_tvalid=1, tlast=0, tuser=0; advance only on m_axis_tready; after byte 5 handshake -> PASS.
REQ-015 PASS: combinational pass-through, m_axis_* = s_axis_* and s_axis_tready = m_axis_tready, zero latency; on tlast handshake frames_passed+1 and -> HDR.
REQ-016 DROP: s_axis_tready=1, m_axis_tvalid=0; on accepted tlast -> HDR.
REQ-017 m_axis_tvalid SHALL never deassert in REPLAY before its handshake (AXI-stream stability).
REQ-018 tuser SHALL propagate unchanged in PASS; tuser on header beats is ignored.
REQ-019 Counters SHALL wrap from 2^CNT_WIDTH-1 to 0; at most one counter increments per cycle.
REQ-020 Minimum header-to-first-payload latency: 6 input beats + 1 DECIDE cycle + 6 REPLAY beats.

Reset
REQ-021 On rst: state HDR, header index 0, buffer 0, frames_passed=0, frames_dropped=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, s_axis_tready=1 once rst deasserts.
REQ-022 Reset mid-frame SHALL abandon the frame without counting; residual input beats after reset are parsed as a new header.
REQ-023 No output SHALL depend on rst synchronously; all state flops clear asynchronously.

Configuration
REQ-024 Macro ETH_RX_FILTER_BCAST_EN defined: destination ff:ff:ff:ff:ff:ff matches; undefined: broadcast matches only via promisc or equality with mac_addr.

Structure
REQ-025 Shared package eth_filter_pkg SHALL hold the state enum, HDR_BYTES=6 and BCAST_ADDR=48'hFFFF_FFFF_FFFF.
REQ-026 No sub-module; single module, one FSM plus datapath.

Verification
REQ-027 mac_addr=02:00:00:00:00:01, frame 64 B to that address, m_axis_tready=1 -> identical 64 B out, frames_passed=1.
REQ-028 Same mac_addr, frame to 02:00:00:00:00:02, promisc=0 -> no output beats, frames_dropped=1, next matching frame passes intact.
REQ-029 Broadcast 60 B frame, promisc=0 -> passed with macro defined, dropped without.
REQ-030 4-byte frame (tlast on beat 3) -> frames_dropped=1, state HDR, following 64 B matching frame passes.
REQ-031 Matching frame, m_axis_tready toggling 1/0 every cycle, tuser=1 on last beat -> all bytes in order, tuser=1 on output tlast, no beat lost or duplicated.
REQ-032 rst pulsed during PASS at byte 20 -> outputs cleared immediately, counters 0, next full matching frame passes.
